// File: rtl/lif_pkg.sv
// Shared types and sizing for the LIF neuron datapath.
package lif_pkg;

  // Refractory controller states.
  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } lif_state_e;

  // Potential width is n_stage+2, matching the membrane accumulator.
  function automatic int lif_w(input int n_stage);
    return n_stage + 2;
  endfunction

  localparam int LIF_N_STAGE_DEFAULT = 6;
  localparam int LIF_W_DEFAULT       = LIF_N_STAGE_DEFAULT + 2;

  // Leak control width (shift amount 0..7).
  localparam int LIF_SHIFT_W = 3;

  // Observation spike counter: 8 bits, saturates instead of wrapping.
  localparam int                   SPK_CNT_W   = 8;
  localparam logic [SPK_CNT_W-1:0] SPK_CNT_SAT = '1;

  // Refractory down-counter width (REFRAC_CYCLES 1..15).
  localparam int RCNT_W = 4;

endpackage

// File: rtl/lif_state_update_leak_shift.sv
// Combinational leak: beta_u = u - (u >>> shift), i.e. beta = 1 - 2^-shift.
// shift = 0 yields 0 (full leak); magnitude never exceeds |u|, so no overflow.
import lif_pkg::*;

module leak_shift #(
  parameter int W = LIF_W_DEFAULT
) (
  input  logic signed [W-1:0]           membrane_i,
  input  logic        [LIF_SHIFT_W-1:0] shift_i,
  output logic signed [W-1:0]           beta_u_o
);

  // Arithmetic shift keeps negative potentials leaking toward zero.
  assign beta_u_o = membrane_i - (membrane_i >>> shift_i);

endmodule

// File: rtl/lif_state_update.sv
// Per-neuron state stage of the LIF datapath: registers the potential on each
// timestep strobe, decides spiking against the threshold, feeds back the
// leaked potential and was_spike flag, and counts spikes (saturating).
// Optional refractory period enabled by defining LIF_REFRACTORY_EN.
import lif_pkg::*;

module lif_state_update #(
  parameter int n_stage       = LIF_N_STAGE_DEFAULT,
  parameter int REFRAC_CYCLES = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          step,
  input  logic signed [n_stage+1:0]     u_in,
  input  logic        [n_stage+1:0]     threshold,
  input  logic        [LIF_SHIFT_W-1:0] shift,
  output logic signed [n_stage+1:0]     membrane,
  output logic signed [n_stage+1:0]     beta_u,
  output logic                          was_spike,
  output logic                          spike,
  output logic                          refractory,
  output logic        [SPK_CNT_W-1:0]   spike_count
);

  localparam int W = lif_w(n_stage);

  // Out-of-range refractory lengths would not fit the down-counter.
  if (REFRAC_CYCLES < 1 || REFRAC_CYCLES > 15) begin : g_bad_refrac
    $error("lif_state_update: REFRAC_CYCLES must be 1..15");
  end

  logic signed [W-1:0]         membrane_q;
  logic                        was_spike_q;
  logic                        spike_q;
  logic        [SPK_CNT_W-1:0] spk_cnt_q, spk_cnt_d;
  logic                        ge_thr;
  logic                        fire;

  // Threshold is unsigned, so widen both sides by one bit and compare signed;
  // a negative potential can then never reach the threshold.
  assign ge_thr = $signed({u_in[W-1], u_in}) >= $signed({1'b0, threshold});

`ifdef LIF_REFRACTORY_EN
  localparam logic [RCNT_W-1:0] RCNT_INIT = RCNT_W'(REFRAC_CYCLES);

  lif_state_e        state_q;
  logic [RCNT_W-1:0] rcnt_q;

  assign fire       = ge_thr && (state_q == INTEGRATE);
  assign refractory = (state_q == REFRACTORY);

  // Refractory FSM: a spike arms the counter; each later step counts down and
  // the step that sees cnt==1 returns to INTEGRATE (that step is still muted).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INTEGRATE;
      rcnt_q  <= '0;
    end else if (step) begin
      case (state_q)
        INTEGRATE: begin
          if (fire) begin
            state_q <= REFRACTORY;
            rcnt_q  <= RCNT_INIT;
          end
        end
        REFRACTORY: begin
          if (rcnt_q == RCNT_W'(1)) begin
            state_q <= INTEGRATE;
            rcnt_q  <= '0;
          end else begin
            rcnt_q  <= rcnt_q - RCNT_W'(1);
          end
        end
        default: begin
          state_q <= INTEGRATE;
          rcnt_q  <= '0;
        end
      endcase
    end
  end
`else
  assign fire       = ge_thr;
  assign refractory = 1'b0;
`endif

  // Saturating increment of the observation counter.
  always_comb begin
    spk_cnt_d = spk_cnt_q;
    if (fire && (spk_cnt_q != SPK_CNT_SAT)) spk_cnt_d = spk_cnt_q + SPK_CNT_W'(1);
  end

  // Timestep commit; spike is forced low on non-step cycles so it is one clock wide.
  always_ff @(posedge clk) begin
    if (reset) begin
      membrane_q  <= '0;
      was_spike_q <= 1'b0;
      spike_q     <= 1'b0;
      spk_cnt_q   <= '0;
    end else if (step) begin
      membrane_q  <= u_in;
      was_spike_q <= fire;
      spike_q     <= fire;
      spk_cnt_q   <= spk_cnt_d;
    end else begin
      spike_q     <= 1'b0;
    end
  end

  leak_shift #(.W(W)) u_leak (
    .membrane_i (membrane_q),
    .shift_i    (shift),
    .beta_u_o   (beta_u)
  );

  assign membrane    = membrane_q;
  assign was_spike   = was_spike_q;
  assign spike       = spike_q;
  assign spike_count = spk_cnt_q;

endmodule

// File: tb/tb_lif_state_update.sv
// Directed bench for lif_state_update (n_stage=6, W=8, threshold=50, shift=2).
// Expectations adapt when LIF_REFRACTORY_EN is defined (REFRAC_CYCLES=2).
module tb_lif_state_update;

  logic              clk;
  logic              reset;
  logic              step;
  logic signed [7:0] u_in;
  logic        [7:0] threshold;
  logic        [2:0] shift;
  logic signed [7:0] membrane;
  logic signed [7:0] beta_u;
  logic              was_spike;
  logic              spike;
  logic              refractory;
  logic        [7:0] spike_count;

  int vectors;
  int miscompares;

  lif_state_update #(.n_stage(6), .REFRAC_CYCLES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .step        (step),
    .u_in        (u_in),
    .threshold   (threshold),
    .shift       (shift),
    .membrane    (membrane),
    .beta_u      (beta_u),
    .was_spike   (was_spike),
    .spike       (spike),
    .refractory  (refractory),
    .spike_count (spike_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one step strobe for one clock; returns at the negedge after the commit edge.
  task automatic do_step(input logic signed [7:0] u);
    @(negedge clk);
    step = 1'b1;
    u_in = u;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit ren;
`ifdef LIF_REFRACTORY_EN
    ren = 1'b1;
`else
    ren = 1'b0;
`endif
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; step = 1'b0; u_in = '0; threshold = 8'd50; shift = 3'd2;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_membrane", membrane, 0);
    chk("rst_beta", beta_u, 0);
    chk("rst_was", was_spike, 0);
    chk("rst_spike", spike, 0);
    chk("rst_refr", refractory, 0);
    chk("rst_count", spike_count, 0);

    // 1: above threshold fires
    do_step(8'sd60);
    chk("t1_membrane", membrane, 60);
    chk("t1_spike", spike, 1);
    chk("t1_was", was_spike, 1);
    chk("t1_beta", beta_u, 45);
    chk("t1_count", spike_count, 1);
    @(negedge clk);
    chk("t1_spike_pulse", spike, 0);
    chk("t1_was_held", was_spike, 1);

    // 2: negative, equality, just below
    do_reset();
    do_step(-8'sd20);
    chk("t2_neg_membrane", membrane, -20);
    chk("t2_neg_beta", beta_u, -15);
    chk("t2_neg_spike", spike, 0);
    chk("t2_neg_was", was_spike, 0);
    do_step(8'sd50);
    chk("t2_eq_spike", spike, 1);
    chk("t2_eq_count", spike_count, 1);
    do_step(8'sd49);
    chk("t2_below_spike", spike, 0);
    chk("t2_below_was", was_spike, 0);
    chk("t2_below_count", spike_count, 1);
    // Leak shift corners on membrane=49
    shift = 3'd0; #1;
    chk("t2_shift0_beta", beta_u, 0);
    shift = 3'd1; #1;
    chk("t2_shift1_beta", beta_u, 25);
    shift = 3'd7; #1;
    chk("t2_shift7_beta", beta_u, 49);
    shift = 3'd2;

    // 3: four consecutive steps at 70
    do_reset();
    do_step(8'sd70);
    chk("t3_s1_spike", spike, 1);
    chk("t3_s1_refr", refractory, ren ? 1 : 0);
    do_step(8'sd70);
    chk("t3_s2_spike", spike, ren ? 0 : 1);
    chk("t3_s2_refr", refractory, ren ? 1 : 0);
    chk("t3_s2_membrane", membrane, 70);
    do_step(8'sd70);
    chk("t3_s3_spike", spike, ren ? 0 : 1);
    chk("t3_s3_refr", refractory, 0);
    do_step(8'sd70);
    chk("t3_s4_spike", spike, 1);
    chk("t3_s4_count", spike_count, ren ? 2 : 4);

    // 4: reset coinciding with a step discards it
    do_reset();
    do_step(8'sd100);
    chk("t4_pre_spike", spike, 1);
    @(negedge clk);
    reset = 1'b1; step = 1'b1; u_in = 8'sd100;
    @(negedge clk);
    reset = 1'b0; step = 1'b0;
    chk("t4_rst_membrane", membrane, 0);
    chk("t4_rst_was", was_spike, 0);
    chk("t4_rst_spike", spike, 0);
    chk("t4_rst_refr", refractory, 0);
    chk("t4_rst_count", spike_count, 0);
    do_step(8'sd100);
    chk("t4_post_spike", spike, 1);
    chk("t4_post_count", spike_count, 1);

    // 6: idle cycles hold state
    @(negedge clk);
    chk("t6_spike_low", spike, 0);
    repeat (9) @(negedge clk);
    chk("t6_membrane", membrane, 100);
    chk("t6_was", was_spike, 1);
    chk("t6_count", spike_count, 1);
    chk("t6_spike", spike, 0);

    // 5: back-to-back spiking steps, counter saturation
    do_reset();
    @(negedge clk);
    step = 1'b1; u_in = 8'sd100;
    repeat (255) @(negedge clk);
    chk("t5_count_255", spike_count, ren ? 85 : 255);
    repeat (45) @(negedge clk);
    step = 1'b0;
    chk("t5_count_300", spike_count, ren ? 100 : 255);
    @(negedge clk);
    chk("t5_count_hold", spike_count, ren ? 100 : 255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
